// File: rtl/la_aopipe_pkg.sv
// rtl/la_aopipe_pkg.sv - mode constants and per-bit AND-OR reduction for la_aopipe
package la_aopipe_pkg;

    localparam logic [1:0] LA_AO  = 2'd0;
    localparam logic [1:0] LA_AOI = 2'd1;
    localparam logic [1:0] LA_OA  = 2'd2;
    localparam logic [1:0] LA_OAI = 2'd3;

    localparam int LA_MAX_OPS = 1024;

    // ops holds one bit slice of every operand, operand (g*k_n+k) at index g*k_n+k
    function automatic logic la_reduce_bit(input logic [LA_MAX_OPS-1:0] ops,
                                           input int g_n, input int k_n,
                                           input logic [1:0] mode);
        logic and_or;
        logic or_and;
        logic term_a;
        logic term_o;
        logic r;
        and_or = 1'b0;
        or_and = 1'b1;
        for (int g = 0; g < g_n; g++) begin
            term_a = 1'b1;
            term_o = 1'b0;
            for (int k = 0; k < k_n; k++) begin
                term_a = term_a & ops[g*k_n+k];
                term_o = term_o | ops[g*k_n+k];
            end
            and_or = and_or | term_a;
            or_and = or_and & term_o;
        end
        r = mode[1] ? or_and : and_or;
        return r ^ mode[0];
    endfunction

endpackage

// File: rtl/la_aopipe_stage.sv
// rtl/la_aopipe_stage.sv - one W-bit valid/ready register stage
module la_aopipe_stage
    import la_aopipe_pkg::*;
#(
    parameter string PROP = "DEFAULT",
    parameter int    W    = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         up_valid,
    input  logic [W-1:0] up_z,
    input  logic         dn_ready,
    output logic         dn_valid,
    output logic [W-1:0] dn_z
);

    logic         valid_q, valid_d;
    logic [W-1:0] z_q, z_d;
    logic         load;

    // Loading when empty lets bubbles collapse even while downstream stalls
    always_comb begin
        load    = !valid_q || dn_ready;
        valid_d = valid_q;
        z_d     = z_q;
        if (load) begin
            valid_d = up_valid;
            if (up_valid) begin
                z_d = up_z;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            z_q     <= '0;
        end else begin
            valid_q <= valid_d;
            z_q     <= z_d;
        end
    end

    assign dn_valid = valid_q;
    assign dn_z     = z_q;

endmodule

// File: rtl/la_aopipe.sv
// rtl/la_aopipe.sv - pipelined AO/AOI/OA/OAI reduction of G groups of K W-bit operands
module la_aopipe
    import la_aopipe_pkg::*;
#(
    parameter string PROP   = "DEFAULT",
    parameter int    W      = 8,
    parameter int    G      = 2,
    parameter int    K      = 3,
    parameter int    STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [G*K*W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_z,
    output logic             busy
);

    logic [W-1:0]          f_z;
    logic [LA_MAX_OPS-1:0] col;

    always_comb begin
        f_z = '0;
        col = '0;
        for (int b = 0; b < W; b++) begin
            col = '0;
            for (int n = 0; n < G*K; n++) begin
                col[n] = in_data[n*W+b];
            end
            f_z[b] = la_reduce_bit(col, G, K, in_mode);
        end
    end

    if (STAGES == 0) begin : g_bypass
        assign out_valid = in_valid;
        assign out_z     = f_z;
        assign in_ready  = out_ready;
        assign busy      = 1'b0;
    end else begin : g_chain
        logic [STAGES:0] vc;
        logic [STAGES:0] rdy;
        logic [W-1:0]    zc [0:STAGES];

        assign vc[0] = in_valid;
        assign zc[0] = f_z;

        // Ready walks back from the output within one process to keep the chain acyclic
        always_comb begin
            rdy         = '0;
            rdy[STAGES] = out_ready;
            for (int i = STAGES - 1; i >= 0; i--) begin
                rdy[i] = rdy[i+1] || !vc[i+1];
            end
        end

        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            la_aopipe_stage #(
                .PROP(PROP),
                .W   (W)
            ) u_stage (
                .clk     (clk),
                .reset   (reset),
                .up_valid(vc[i]),
                .up_z    (zc[i]),
                .dn_ready(rdy[i+1]),
                .dn_valid(vc[i+1]),
                .dn_z    (zc[i+1])
            );
        end

        assign in_ready  = rdy[0];
        assign out_valid = vc[STAGES];
        assign out_z     = zc[STAGES];
        assign busy      = |vc[STAGES:1];
    end

endmodule

// File: tb/tb_la_aopipe.sv
// tb/tb_la_aopipe.sv - self-checking bench for la_aopipe (STAGES=2 and STAGES=0)
module tb_la_aopipe;
    import la_aopipe_pkg::*;

    localparam int W = 4;
    localparam int G = 2;
    localparam int K = 3;
    localparam int N = G*K*W;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [1:0]   in_mode;
    logic [N-1:0] in_data;
    logic [W-1:0] out_z;

    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [1:0]   b_in_mode;
    logic [N-1:0] b_in_data;
    logic [W-1:0] b_out_z;

    la_aopipe #(.PROP("DEFAULT"), .W(W), .G(G), .K(K), .STAGES(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_z(out_z), .busy(busy)
    );

    la_aopipe #(.PROP("DEFAULT"), .W(W), .G(G), .K(K), .STAGES(0)) dut_bypass (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_mode(b_in_mode), .in_data(b_in_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_z(b_out_z), .busy(b_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   mode;
        logic [N-1:0] data;
        logic [W-1:0] z;
    } vec_t;

    vec_t         tbl [5];
    logic [W-1:0] sb [$];
    int           n_vec = 0;
    int           n_err = 0;
    int           pop_cnt = 0;

    function automatic logic [W-1:0] model(input logic [N-1:0] d, input logic [1:0] m);
        logic [W-1:0] ao, oa, ga, go, r;
        ao = '0;
        oa = '1;
        for (int g = 0; g < G; g++) begin
            ga = '1;
            go = '0;
            for (int k = 0; k < K; k++) begin
                ga = ga & d[(g*K+k)*W +: W];
                go = go | d[(g*K+k)*W +: W];
            end
            ao = ao | ga;
            oa = oa & go;
        end
        r = (m == LA_OA || m == LA_OAI) ? oa : ao;
        if (m == LA_AOI || m == LA_OAI) r = ~r;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Handshakes sampled mid-cycle commit at the following rising edge
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                check("sb_pop_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    check("sb_order", 32'(out_z), 32'(sb.pop_front()));
                    pop_cnt++;
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_data, in_mode));
        end
    end

    initial begin
        logic [N-1:0] d [3];
        int           p0;

        tbl[0] = '{LA_AO,  24'h653FFF, 4'hF};
        tbl[1] = '{LA_AO,  24'h7138AC, 4'h9};
        tbl[2] = '{LA_AOI, 24'h7138AC, 4'h6};
        tbl[3] = '{LA_OA,  24'h7138AC, 4'h6};
        tbl[4] = '{LA_OAI, 24'h7138AC, 4'h9};

        in_valid = 1'b0; in_mode = LA_AO; in_data = '0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_mode = LA_AO; b_in_data = '0; b_out_ready = 1'b1;

        #1 reset = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_z", 32'(out_z), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1 reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            in_data = tbl[i].data; in_mode = tbl[i].mode; in_valid = 1'b1;
            @(posedge clk); #1 in_valid = 1'b0;
            check("lat_not_early", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
            check("tbl_valid", 32'(out_valid), 32'd1);
            check("tbl_z", 32'(out_z), 32'(tbl[i].z));
        end
        @(posedge clk); #1;
        check("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 3; i++) d[i] = N'($urandom);
        p0 = pop_cnt;
        out_ready = 1'b0; in_valid = 1'b1; in_mode = LA_AO; in_data = d[0];
        @(posedge clk); #1 in_data = d[1];
        @(posedge clk); #1 in_data = d[2];
        for (int c = 0; c < 3; c++) begin
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_accepted", 32'(sb.size()), 32'd2);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_hold_z", 32'(out_z), 32'(model(d[0], LA_AO)));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1 check("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("bp_drained_busy", 32'(busy), 32'd0);
        check("bp_sb_empty", 32'(sb.size()), 32'd0);
        check("bp_pop_count", 32'(pop_cnt - p0), 32'd3);

        p0 = pop_cnt;
        in_mode = LA_OAI;
        for (int i = 0; i < 20; i++) begin
            in_data = N'(i * 24'h010203 + i); in_valid = 1'b1;
            @(posedge clk); #1;
            check("stream_busy", 32'(busy), 32'd1);
        end
        in_valid = 1'b0;
        @(posedge clk); #1 check("stream_busy_tail", 32'(busy), 32'd1);
        @(posedge clk); #1 check("stream_busy_end", 32'(busy), 32'd0);
        check("stream_count", 32'(pop_cnt - p0), 32'd20);

        out_ready = 1'b0; in_mode = LA_AO; in_data = 24'h7138AC; in_valid = 1'b1;
        @(posedge clk); #1 in_data = 24'h653FFF;
        @(posedge clk); #1 in_valid = 1'b0;
        check("inflight_busy", 32'(busy), 32'd1);
        #3 reset = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_z", 32'(out_z), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        @(posedge clk); #1 reset = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1 check("no_stale_out", 32'(out_valid), 32'd0);
        end

        b_out_ready = 1'b0; b_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b_in_data = tbl[i].data; b_in_mode = tbl[i].mode;
            #1;
            check("byp_out_valid", 32'(b_out_valid), 32'd1);
            check("byp_in_ready", 32'(b_in_ready), 32'd0);
            check("byp_z", 32'(b_out_z), 32'(tbl[i].z));
            check("byp_busy", 32'(b_busy), 32'd0);
        end
        b_out_ready = 1'b1;
        #1 check("byp_ready_follow", 32'(b_in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/la_aopipe.md
# la_aopipe

Parametrised, pipelined AND-OR logic block: G groups of K W-bit operands, each group reduced bitwise by AND (or OR), group results combined by OR (or AND), with optional output inversion selected per transaction. The result passes through STAGES valid/ready register stages, so wide AO/OA/AOI/OAI reductions can be retimed into datapaths without breaking timing. It generalises the fixed 2x3 single-bit and-or cells in the standard cell library into a configurable, flow-controlled block.

## Interface
- PROP, "DEFAULT": implementation property string, passed through unchanged to sub-modules.
- W, 8: bit width of each operand (bitwise function, slices independent).
- G, 2: number of groups (>=1).
- K, 3: operands per group (>=1).
- STAGES, 2: register stages between input and output (0..8); 0 is a combinational passthrough.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand vector valid.
- in_ready  output  1  block accepts the vector this cycle.
- in_mode  input  2  function: 0 AO, 1 AOI, 2 OA, 3 OAI.
- in_data  input  G*K*W  operands; operand k of group g at bits [(g*K+k)*W +: W].
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_z  output  W  result.
- busy  output  1  any stage holds valid data.

## Operation
- AO: z = OR over g of (AND over k of operand[g][k]). OA: z = AND over g of (OR over k). AOI/OAI: bitwise inverse of AO/OA.
- Function evaluated combinationally on in_data/in_mode; only the W-bit result (not operands or mode) is registered into stage 0.
- Transfer at a boundary when valid & ready both high at the clock edge.
- Each stage i holds {valid_i, z_i}. Stage i loads from upstream when it is empty or its downstream accepts this cycle (bubble-collapsing). Stage 0 upstream is the input port; last stage drives out_valid/out_z.
- in_ready = !valid_0 | ready_into_stage_1 (ready chain combinational from out_ready; no skid buffer).
- Data in a stage not accepted downstream holds value stably; out_z must not change while out_valid & !out_ready.
- STAGES=0: out_valid=in_valid, out_z=f(in_data,in_mode), in_ready=out_ready, busy=0.
- busy = OR of all valid_i.

## Timing
- Reset (asserted, async): all valid_i=0, all z_i=0, so out_valid=0, out_z=0, busy=0; in_ready=1 (STAGES>=1) immediately, without clock.
- Reset mid-operation: all in-flight results discarded; no output emitted after deassertion until new input accepted.
- Latency: input accepted at edge n appears on out_z/out_valid after edge n+STAGES-1, i.e. visible in cycle n+STAGES with out_ready continuously high.
- Throughput: one result per cycle with out_ready high; full capacity STAGES results.
- Full: all stages valid and out_ready=0 -> in_ready=0; first cycle out_ready returns high, in_ready=1 same cycle (simultaneous drain and fill).
- Empty pipeline: results pass through without stalling; bubbles collapse when out_ready low.
- Results emerge in acceptance order; none dropped or duplicated.

## Structure
- Package la_aopipe_pkg: mode constants LA_AO=2'd0, LA_AOI=2'd1, LA_OA=2'd2, LA_OAI=2'd3 and the reduction function (in_data, mode) -> W bits.
- Sub-module la_aopipe_stage: one W-bit valid/ready register stage with async active-high reset; instantiated STAGES times in a generate loop.
- Top module: reduction function, generate chain, busy OR-reduce, STAGES=0 bypass.

## Test plan
- W=4,G=2,K=3,STAGES=2, mode AO, group0 operands all 4'hF, group1 {4'h3,4'h5,4'h6}, out_ready=1 -> out_z=4'hF two cycles after accept; group0 {4'hC,4'hA,4'h8}, group1 {4'h3,4'h1,4'h7} -> 4'h9.
- Same operands group0 {4'hC,4'hA,4'h8}, group1 {4'h3,4'h1,4'h7}: AOI -> 4'h6; OA -> (C|A|8)&(3|1|7)=4'hE&4'h7=4'h6; OAI -> 4'h9.
- Backpressure: out_ready=0, push 3 vectors -> in_ready drops after 2 accepted, out_z holds first result stable; raise out_ready -> results in order, one per cycle, in_ready=1 same cycle.
- Streaming: in_valid=1, out_ready=1 for 20 cycles with incrementing operands -> 20 results, correct order, latency 2, busy=1 throughout, busy=0 two cycles after last accept.
- Reset asserted with 2 results in flight (asynchronously, mid-cycle) -> out_valid=0, out_z=0, busy=0 immediately; after release no stale output.
- STAGES=0: in_valid=1,out_ready=0 -> out_valid=1,in_ready=0, out_z combinational matches mode function same cycle.
